// File: rtl/sdr_app_txn_monitor_pkg.sv
// Shared definitions for the SDRAM application-bus transaction monitor:
// error bit map, error vector width and write-tracking FSM states.
package sdr_mon_pkg;

  localparam int unsigned ERR_W = 6;

  typedef enum int unsigned {
    E_REQ_DROP = 0,
    E_LEN_ZERO = 1,
    E_WR_BEAT  = 2,
    E_WR_OVLP  = 3,
    E_RD_BEAT  = 4,
    E_RD_OVF   = 5
  } err_bit_e;

  typedef logic [ERR_W-1:0] err_vec_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sdr_app_txn_monitor_if.sv
// Application-side SDRAM controller bus as seen by the monitor: request
// handshake plus write-beat and read-beat strobes.
interface sdr_app_txn_monitor_if #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned BL     = 9
);
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [BL-1:0]     app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic              app_wr_next_req;
  logic              app_last_wr;
  logic              app_rd_valid;
  logic              app_last_rd;

  modport master (
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_ack,
           app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd
  );

  modport slave (
    input app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_ack,
          app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd
  );
endinterface

// File: rtl/sdr_app_txn_monitor_len_fifo.sv
// Register FIFO holding burst lengths of accepted, not yet completed reads.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sdr_mon_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sdr_app_txn_monitor.sv
// Protocol monitor for the SDRAM controller application bus: request-hold
// checking, write burst FSM, read burst tracking, sticky errors and counters.
module sdr_app_txn_monitor
  import sdr_mon_pkg::*;
#(
  parameter int unsigned APP_AW   = 26,
  parameter int unsigned BL       = 9,
  parameter int unsigned RD_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_resetn,
  input  logic                        mon_clr,
  sdr_app_txn_monitor_if.slave        app,
  output logic [ERR_W-1:0]            err_sticky,
  output logic                        err_pulse,
  output logic [$clog2(RD_DEPTH):0]   rd_outstanding,
  output logic [CNT_W-1:0]            wr_txn_cnt,
  output logic [CNT_W-1:0]            rd_txn_cnt
);
  localparam logic [BL:0] ONE_X = (BL+1)'(1);

  // Request-hold capture
  logic              hold_vld;
  logic [APP_AW-1:0] hold_addr;
  logic [BL-1:0]     hold_len;
  logic              hold_wr_n;

  logic req_acc;
  logic len_zero;
  logic wr_open_req;
  logic rd_open_req;

  wr_state_e     wr_state, wr_state_nx;
  logic [BL-1:0] wcnt, wcnt_nx;
  logic [BL-1:0] wlen, wlen_nx;
  logic          w_open;
  logic [BL-1:0] w_cnt;
  logic [BL-1:0] w_len;
  logic          w_final;
  logic          wr_done;

  logic [BL-1:0] rcnt, rcnt_nx;
  logic          r_final;
  logic          rd_done;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [BL-1:0]             fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(RD_DEPTH):0] fifo_count;

  err_vec_t new_err;

  assign req_acc     = app.app_req && app.app_req_ack;
  assign len_zero    = (app.app_req_len == '0);
  assign wr_open_req = req_acc && !len_zero && !app.app_req_wr_n;
  assign rd_open_req = req_acc && !len_zero &&  app.app_req_wr_n;

  sdr_mon_len_fifo #(
    .DEPTH (RD_DEPTH),
    .W     (BL)
  ) u_len_fifo (
    .clk   (sdram_clk),
    .rst_n (sdram_resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (app.app_req_len),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) wr_state <= W_IDLE;
    else               wr_state <= wr_state_nx;
  end

  always_comb begin
    new_err     = '0;
    wr_state_nx = wr_state;
    w_open      = 1'b0;
    w_cnt       = wcnt;
    w_len       = wlen;
    w_final     = 1'b0;
    wcnt_nx     = wcnt;
    wlen_nx     = wlen;
    wr_done     = 1'b0;
    r_final     = 1'b0;
    rcnt_nx     = rcnt;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    rd_done     = 1'b0;

    if (hold_vld && (!app.app_req || app.app_req_addr != hold_addr ||
                     app.app_req_len != hold_len || app.app_req_wr_n != hold_wr_n))
      new_err[E_REQ_DROP] = 1'b1;

    if (req_acc && len_zero) new_err[E_LEN_ZERO] = 1'b1;

    // A write ack opens the burst before this cycle's beat is judged, so a
    // beat in the ack cycle already belongs to the new burst.
    if (wr_open_req) begin
      if (wr_state == W_DATA) new_err[E_WR_OVLP] = 1'b1;
      w_open = 1'b1;
      w_cnt  = '0;
      w_len  = app.app_req_len;
    end else begin
      w_open = (wr_state == W_DATA);
    end
    w_final     = (({1'b0, w_cnt} + ONE_X) == {1'b0, w_len});
    wcnt_nx     = w_cnt;
    wlen_nx     = w_len;
    wr_state_nx = w_open ? W_DATA : W_IDLE;

    if (app.app_wr_next_req) begin
      if (!w_open) begin
        new_err[E_WR_BEAT] = 1'b1;
      end else begin
        if (w_final != app.app_last_wr) new_err[E_WR_BEAT] = 1'b1;
        if (w_final) begin
          wr_state_nx = W_IDLE;
          wcnt_nx     = '0;
          wr_done     = 1'b1;
        end else begin
          wcnt_nx = w_cnt + BL'(1);
        end
      end
    end

    if (app.app_rd_valid) begin
      if (fifo_empty) begin
        new_err[E_RD_BEAT] = 1'b1;
      end else begin
        r_final = (({1'b0, rcnt} + ONE_X) == {1'b0, fifo_head});
        if (r_final != app.app_last_rd) new_err[E_RD_BEAT] = 1'b1;
        if (r_final) begin
          fifo_pop = 1'b1;
          rcnt_nx  = '0;
          rd_done  = 1'b1;
        end else begin
          rcnt_nx = rcnt + BL'(1);
        end
      end
    end

    if (rd_open_req) begin
      fifo_push = 1'b1;
      if (fifo_full && !fifo_pop) new_err[E_RD_OVF] = 1'b1;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      hold_vld   <= 1'b0;
      hold_addr  <= '0;
      hold_len   <= '0;
      hold_wr_n  <= 1'b0;
      wcnt       <= '0;
      wlen       <= '0;
      rcnt       <= '0;
      err_sticky <= '0;
      err_pulse  <= 1'b0;
      wr_txn_cnt <= '0;
      rd_txn_cnt <= '0;
    end else begin
      hold_vld  <= app.app_req && !app.app_req_ack;
      hold_addr <= app.app_req_addr;
      hold_len  <= app.app_req_len;
      hold_wr_n <= app.app_req_wr_n;
      wcnt      <= wcnt_nx;
      wlen      <= wlen_nx;
      rcnt      <= rcnt_nx;
      err_pulse <= |new_err;
      if (mon_clr) begin
        err_sticky <= '0;
        wr_txn_cnt <= '0;
        rd_txn_cnt <= '0;
      end else begin
        err_sticky <= err_sticky | new_err;
        if (wr_done && wr_txn_cnt != '1) wr_txn_cnt <= wr_txn_cnt + CNT_W'(1);
        if (rd_done && rd_txn_cnt != '1) rd_txn_cnt <= rd_txn_cnt + CNT_W'(1);
      end
    end
  end

  assign rd_outstanding = fifo_count;
endmodule

// File: tb/tb_sdr_app_txn_monitor.sv
// Bench for sdr_app_txn_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_sdr_app_txn_monitor;
  localparam int unsigned APP_AW   = 26;
  localparam int unsigned BL       = 9;
  localparam int unsigned RD_DEPTH = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned OW       = $clog2(RD_DEPTH) + 1;
  localparam int          SAT      = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mon_clr;
  logic [5:0]        err_sticky;
  logic              err_pulse;
  logic [OW-1:0]     rd_outstanding;
  logic [CNT_W-1:0]  wr_txn_cnt;
  logic [CNT_W-1:0]  rd_txn_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sdr_app_txn_monitor_if #(.APP_AW(APP_AW), .BL(BL)) app_if ();

  sdr_app_txn_monitor #(
    .APP_AW   (APP_AW),
    .BL       (BL),
    .RD_DEPTH (RD_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .sdram_clk      (clk),
    .sdram_resetn   (rst_n),
    .mon_clr        (mon_clr),
    .app            (app_if),
    .err_sticky     (err_sticky),
    .err_pulse      (err_pulse),
    .rd_outstanding (rd_outstanding),
    .wr_txn_cnt     (wr_txn_cnt),
    .rd_txn_cnt     (rd_txn_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: open write burst as beats remaining, reads as a queue of beats remaining
  bit                m_hold;
  logic [APP_AW-1:0] m_addr;
  int                m_len;
  logic              m_wr_n;
  int                wr_left;
  int                rq[$];
  int                m_wr_cnt;
  int                m_rd_cnt;
  logic [5:0]        m_sticky;
  logic [5:0]        exp_sticky;
  logic              exp_pulse;
  int                exp_outst;
  int                exp_wr;
  int                exp_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_addr = '0; m_len = 0; m_wr_n = 1'b0;
    wr_left = 0; rq.delete();
    m_wr_cnt = 0; m_rd_cnt = 0; m_sticky = '0;
    exp_sticky = '0; exp_pulse = 1'b0; exp_outst = 0; exp_wr = 0; exp_rd = 0;
  endtask

  task automatic model_step();
    logic [5:0] e;
    bit acc;
    int len;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e   = '0;
    len = int'(app_if.app_req_len);
    if (m_hold && (!app_if.app_req || app_if.app_req_addr != m_addr ||
                   len != m_len || app_if.app_req_wr_n != m_wr_n))
      e[0] = 1'b1;
    m_hold = app_if.app_req && !app_if.app_req_ack;
    m_addr = app_if.app_req_addr;
    m_len  = len;
    m_wr_n = app_if.app_req_wr_n;
    acc = app_if.app_req && app_if.app_req_ack;
    if (acc && len == 0) e[1] = 1'b1;
    if (acc && len > 0 && !app_if.app_req_wr_n) begin
      if (wr_left > 0) e[3] = 1'b1;
      wr_left = len;
    end
    if (app_if.app_wr_next_req) begin
      if (wr_left == 0) e[2] = 1'b1;
      else begin
        if ((wr_left == 1) != app_if.app_last_wr) e[2] = 1'b1;
        wr_left--;
        if (wr_left == 0 && m_wr_cnt < SAT) m_wr_cnt++;
      end
    end
    if (app_if.app_rd_valid) begin
      if (rq.size() == 0) e[4] = 1'b1;
      else begin
        rq[0] = rq[0] - 1;
        if ((rq[0] == 0) != app_if.app_last_rd) e[4] = 1'b1;
        if (rq[0] == 0) begin
          void'(rq.pop_front());
          if (m_rd_cnt < SAT) m_rd_cnt++;
        end
      end
    end
    if (acc && len > 0 && app_if.app_req_wr_n) begin
      if (rq.size() == RD_DEPTH) e[5] = 1'b1;
      else rq.push_back(len);
    end
    if (mon_clr) begin
      m_sticky = '0; m_wr_cnt = 0; m_rd_cnt = 0;
    end else begin
      m_sticky = m_sticky | e;
    end
    exp_sticky = m_sticky;
    exp_pulse  = |e;
    exp_outst  = rq.size();
    exp_wr     = m_wr_cnt;
    exp_rd     = m_rd_cnt;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
      chk("err_pulse", 64'(err_pulse), 64'(exp_pulse));
      chk("rd_outstanding", 64'(rd_outstanding), 64'(exp_outst));
      chk("wr_txn_cnt", 64'(wr_txn_cnt), 64'(exp_wr));
      chk("rd_txn_cnt", 64'(rd_txn_cnt), 64'(exp_rd));
    end
  end

  task automatic idle();
    app_if.app_req = 1'b0; app_if.app_req_ack = 1'b0;
    app_if.app_wr_next_req = 1'b0; app_if.app_last_wr = 1'b0;
    app_if.app_rd_valid = 1'b0; app_if.app_last_rd = 1'b0;
    mon_clr = 1'b0;
  endtask

  // Inputs are set at negedge+1; outputs of that cycle are visible at the return
  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic ack_req(input logic wr_n, input int len);
    idle();
    app_if.app_req = 1'b1; app_if.app_req_ack = 1'b1;
    app_if.app_req_wr_n = wr_n; app_if.app_req_len = BL'(len);
    app_if.app_req_addr = APP_AW'($urandom);
    tick();
    idle();
  endtask

  task automatic wr_beat(input logic last);
    idle();
    app_if.app_wr_next_req = 1'b1; app_if.app_last_wr = last;
    tick();
    idle();
  endtask

  task automatic rd_beat(input logic last);
    idle();
    app_if.app_rd_valid = 1'b1; app_if.app_last_rd = last;
    tick();
    idle();
  endtask

  bit                g_act;
  logic [APP_AW-1:0] g_addr;
  int unsigned       g_len;
  logic              g_wr_n;

  initial begin
    rst_n = 1'b0;
    app_if.app_req_addr = '0; app_if.app_req_len = '0; app_if.app_req_wr_n = 1'b0;
    idle();
    model_reset();
    chk_en = 1'b1;
    @(negedge clk); #1;
    tick();
    chk("reset_sticky", 64'(err_sticky), 64'd0);
    chk("reset_outst", 64'(rd_outstanding), 64'd0);
    rst_n = 1'b1;
    tick();

    // Clean write burst of 4
    do_reset();
    ack_req(1'b0, 4);
    for (int b = 1; b <= 4; b++) wr_beat(b == 4);
    chk("wr4_cnt", 64'(wr_txn_cnt), 64'd1);
    chk("wr4_sticky", 64'(err_sticky), 64'd0);
    chk("model_wr4_cnt", 64'(exp_wr), 64'd1);

    // Early last_wr on beat 3
    do_reset();
    ack_req(1'b0, 4);
    for (int b = 1; b <= 3; b++) wr_beat(b == 3);
    chk("early_last_sticky", 64'(err_sticky), 64'b000100);
    chk("early_last_pulse", 64'(err_pulse), 64'd1);
    tick();
    chk("early_last_pulse_gone", 64'(err_pulse), 64'd0);
    chk("model_early_last", 64'(exp_sticky), 64'b000100);

    // Reads 2,3,1 back to back
    do_reset();
    ack_req(1'b1, 2); ack_req(1'b1, 3); ack_req(1'b1, 1);
    chk("rd3_outst", 64'(rd_outstanding), 64'd3);
    for (int b = 1; b <= 2; b++) rd_beat(b == 2);
    for (int b = 1; b <= 3; b++) rd_beat(b == 3);
    rd_beat(1'b1);
    chk("rd3_cnt", 64'(rd_txn_cnt), 64'd3);
    chk("rd3_outst_done", 64'(rd_outstanding), 64'd0);
    chk("rd3_sticky", 64'(err_sticky), 64'd0);

    // Five read acks into depth 4
    do_reset();
    for (int k = 0; k < 5; k++) ack_req(1'b1, 2);
    chk("ovf_outst", 64'(rd_outstanding), 64'd4);
    chk("ovf_sticky", 64'(err_sticky), 64'b100000);
    chk("model_ovf_outst", 64'(exp_outst), 64'd4);

    // Held request changes address; mon_clr against a same-cycle drop error
    do_reset();
    idle();
    app_if.app_req = 1'b1; app_if.app_req_ack = 1'b1; app_if.app_req_wr_n = 1'b0;
    app_if.app_req_len = BL'(1);
    app_if.app_wr_next_req = 1'b1; app_if.app_last_wr = 1'b1;
    tick();
    chk("len1_wr_cnt", 64'(wr_txn_cnt), 64'd1);
    idle();
    app_if.app_req = 1'b1; app_if.app_req_addr = APP_AW'(32'h100);
    app_if.app_req_len = BL'(3); app_if.app_req_wr_n = 1'b1;
    tick();
    app_if.app_req_addr = APP_AW'(32'h101);
    tick();
    chk("drop_sticky", 64'(err_sticky), 64'b000001);
    idle();
    mon_clr = 1'b1;
    tick();
    chk("clr_sticky", 64'(err_sticky), 64'd0);
    chk("clr_pulse", 64'(err_pulse), 64'd1);
    chk("clr_wr_cnt", 64'(wr_txn_cnt), 64'd0);
    idle();
    tick();

    // Reset in the middle of a write burst
    do_reset();
    ack_req(1'b0, 4);
    wr_beat(1'b0); wr_beat(1'b0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("midrst_sticky", 64'(err_sticky), 64'd0);
    chk("midrst_pulse", 64'(err_pulse), 64'd0);
    chk("midrst_wr_cnt", 64'(wr_txn_cnt), 64'd0);

    // Counter saturation
    do_reset();
    for (int k = 0; k < SAT + 2; k++) begin
      idle();
      app_if.app_req = 1'b1; app_if.app_req_ack = 1'b1; app_if.app_req_wr_n = 1'b0;
      app_if.app_req_len = BL'(1);
      app_if.app_wr_next_req = 1'b1; app_if.app_last_wr = 1'b1;
      tick();
    end
    idle();
    chk("sat_wr_cnt", 64'(wr_txn_cnt), 64'(SAT));
    chk("sat_sticky", 64'(err_sticky), 64'd0);

    // Push and pop together while full, then a zero-length ack
    do_reset();
    for (int k = 0; k < 4; k++) ack_req(1'b1, 1);
    idle();
    app_if.app_req = 1'b1; app_if.app_req_ack = 1'b1; app_if.app_req_wr_n = 1'b1;
    app_if.app_req_len = BL'(1);
    app_if.app_rd_valid = 1'b1; app_if.app_last_rd = 1'b1;
    tick();
    chk("full_pp_outst", 64'(rd_outstanding), 64'd4);
    chk("full_pp_sticky", 64'(err_sticky), 64'd0);
    chk("full_pp_rd_cnt", 64'(rd_txn_cnt), 64'd1);
    ack_req(1'b0, 0);
    chk("len0_sticky", 64'(err_sticky), 64'b000010);

    // Randomized traffic, mostly well-formed with occasional protocol faults
    do_reset();
    g_act = 1'b0; g_addr = '0; g_len = 0; g_wr_n = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      idle();
      if (!rst_n) begin
        if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      if (!g_act && $urandom_range(0, 2) == 0) begin
        g_act  = 1'b1;
        g_addr = APP_AW'($urandom);
        g_len  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
        g_wr_n = 1'($urandom_range(0, 1));
      end
      if (g_act) begin
        app_if.app_req = 1'b1; app_if.app_req_addr = g_addr;
        app_if.app_req_len = BL'(g_len); app_if.app_req_wr_n = g_wr_n;
        case ($urandom_range(0, 49))
          0: app_if.app_req = 1'b0;
          1: app_if.app_req_addr = g_addr ^ APP_AW'(1);
          default: ;
        endcase
        if (app_if.app_req && $urandom_range(0, 2) == 0) begin
          app_if.app_req_ack = 1'b1;
          g_act = 1'b0;
        end
      end
      if (wr_left > 0 && $urandom_range(0, 1) == 1) begin
        app_if.app_wr_next_req = 1'b1;
        app_if.app_last_wr = (wr_left == 1) ^ ($urandom_range(0, 19) == 0);
      end else if ($urandom_range(0, 49) == 0) begin
        app_if.app_wr_next_req = 1'b1;
        app_if.app_last_wr = 1'($urandom_range(0, 1));
      end
      if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
        app_if.app_rd_valid = 1'b1;
        app_if.app_last_rd = (rq[0] == 1) ^ ($urandom_range(0, 19) == 0);
      end else if ($urandom_range(0, 49) == 0) begin
        app_if.app_rd_valid = 1'b1;
        app_if.app_last_rd = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) mon_clr = 1'b1;
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
